// File: rtl/tx_arbiter.sv
// Two-requester round-robin arbiter feeding a byte-serial transmitter.
// Each grant launches one frame, followed by an enforced idle gap.
module tx_arbiter #(
  parameter int FRAME_CYCLES = 30,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       grant_id
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FRAME = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [7:0] FRAME_LOAD = 8'(FRAME_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD   = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  logic [1:0] state;
  logic [7:0] cnt;
  logic       last;
  logic       pick;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    pick = req1;
    if (req0 && req1) pick = ~last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      last     <= 1'b1;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      grant_id <= 1'b0;
    end else begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            ack0     <= ~pick;
            ack1     <= pick;
            tx_start <= 1'b1;
            tx_data  <= pick ? data1 : data0;
            grant_id <= pick;
            last     <= pick;
            cnt      <= FRAME_LOAD;
            state    <= FRAME;
            busy     <= 1'b1;
          end
        end
        FRAME: begin
          if (cnt == 8'd0) begin
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= GAP;
              cnt   <= GAP_LOAD;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          // Expiry edge only returns to IDLE; arbitration waits one more edge.
          if (cnt == 8'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
